store_buffer: RTL

- Word-wide posted-write buffer between the MEM pipeline stage and the data memory; it owns the data memory's single port.
- Stores from MEM are queued in a small FIFO so the pipeline does not wait for the memory write.
- The FIFO drains to memory on cycles when no load needs the port.
- Loads that match a buffered store get that data forwarded; otherwise they read memory combinationally, as before.

---
 rtl/store_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and the data memory.
// The buffer owns the single data memory port. Loads take the port first.
// Buffered stores drain in program order on cycles with no load. A load
// that matches a buffered word gets the youngest matching store's data.
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-low reset
//   st_valid/addr/data store request from MEM (address bits [1:0] ignored)
//   st_ready          buffer not full (registered count only)
//   ld_valid/addr     load request from MEM
//   ld_data, ld_hit   load result (0 when idle); ld_hit = forwarded from buffer
//   mem_*             data memory port (combinational read data in)
//   empty             no buffered stores
module store_buffer #(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic [31:0] ld_data,
    output logic        ld_hit,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data,
    output logic        empty
);

    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

    logic [29:0]         entry_addr [DEPTH];
    logic [31:0]         entry_data [DEPTH];
    logic [DEPTH-1:0]    entry_valid;
    logic [PTR_BITS-1:0] head;
    logic [PTR_BITS-1:0] tail;
    logic [PTR_BITS:0]   count;

    logic                push;
    logic                drain;
    logic                fwd_hit;
    logic [31:0]         fwd_data;
    logic [PTR_BITS-1:0] scan_idx;
    logic                unused_st_bits;

    assign unused_st_bits = ^st_addr[1:0];

    assign st_ready = (count != FULL_COUNT);
    assign empty    = (count == '0);
    assign push     = st_valid && st_ready;
    assign drain    = (count != '0) && !ld_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            // push and drain never target the same slot: drain needs
            // count>0 and push needs count<DEPTH, so head!=tail whenever
            // both happen in one cycle.
            if (drain) begin
                head              <= head + 1'b1;
                entry_valid[head] <= 1'b0;
            end
            if (push) begin
                tail              <= tail + 1'b1;
                entry_valid[tail] <= 1'b1;
            end
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset; entry_valid/count qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr[tail] <= st_addr[31:2];
            entry_data[tail] <= st_data;
        end
    end

    // Scan oldest to youngest from head so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_BITS'(i);
            if (((PTR_BITS+1)'(i) < count) && entry_valid[scan_idx] &&
                (entry_addr[scan_idx] == ld_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[scan_idx];
            end
        end
    end

    always_comb begin
        mem_addr    = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_wr_data = '0;
        ld_data     = '0;
        ld_hit      = 1'b0;
        if (ld_valid) begin
            mem_rd   = 1'b1;
            mem_addr = ld_addr;
            ld_hit   = fwd_hit;
            ld_data  = fwd_hit ? fwd_data : mem_rd_data;
        end else if (drain) begin
            mem_wr      = 1'b1;
            mem_addr    = {entry_addr[head], 2'b00};
            mem_wr_data = entry_data[head];
        end
    end

endmodule
